// File: rtl/pix_pair_stream_out.sv
// Pixel-pair output stage: tags each sampled pair with sof/eol and buffers it
// in a small FIFO drained over valid/ready; overflow drops whole frames.
module pix_pair_stream_out #(
  parameter int WIDTH_PIX       = 8,
  parameter int BIT_DEPTH_PIX   = 11,
  parameter int BIT_DEPTH_LINES = 10,
  parameter int ACTIVE_PIX      = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int DEPTH           = 16
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [BIT_DEPTH_PIX-1:0]     pix,
  input  logic [BIT_DEPTH_LINES-1:0]   lines,
  input  logic [2*WIDTH_PIX-1:0]       pair_in,
  output logic [2*WIDTH_PIX-1:0]       m_data,
  output logic                         m_sof,
  output logic                         m_eol,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2*WIDTH_PIX + 2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DROP = 1'b1;

  localparam logic [BIT_DEPTH_PIX-1:0]   PIX_END   = BIT_DEPTH_PIX'(ACTIVE_PIX);
  localparam logic [BIT_DEPTH_PIX-1:0]   PIX_LAST  = BIT_DEPTH_PIX'(ACTIVE_PIX - 1);
  localparam logic [BIT_DEPTH_PIX-1:0]   PIX_FIRST = BIT_DEPTH_PIX'(1);
  localparam logic [BIT_DEPTH_LINES-1:0] LINE_END  = BIT_DEPTH_LINES'(ACTIVE_LINES);
  localparam logic [BIT_DEPTH_LINES-1:0] LINE_ZERO = BIT_DEPTH_LINES'(0);
  localparam logic [AW:0]                LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]                LVL_ZERO  = (AW+1)'(0);

  logic             wr_req_s;
  logic             sof_s;
  logic             eol_s;
  logic             pop_s;
  logic             room_s;
  logic             wr_s;
  logic [EW-1:0]    entry_s;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [0:0]       state_q, state_d;
  logic             ovf_q, ovf_d;
  logic [EW-1:0]    head_q, head_d;
  logic             valid_q, valid_d;

  always_comb begin
    wr_req_s = enable & pix[0] & (pix < PIX_END) & (lines < LINE_END);
    sof_s    = (pix == PIX_FIRST) & (lines == LINE_ZERO);
    eol_s    = (pix == PIX_LAST);
    entry_s  = {sof_s, eol_s, pair_in};
    pop_s    = valid_q & m_ready;
    room_s   = (level_q < LVL_FULL) | pop_s;
  end

  // Once a pair is lost, everything up to the next admissible sof is discarded.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    wr_s    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (wr_req_s && room_s) begin
          wr_s = 1'b1;
        end else if (wr_req_s) begin
          ovf_d   = 1'b1;
          state_d = ST_DROP;
        end else begin
          wr_s = 1'b0;
        end
      end
      ST_DROP: begin
        if (wr_req_s && sof_s && room_s) begin
          wr_s    = 1'b1;
          state_d = ST_RUN;
        end else begin
          wr_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // The head register bypasses the array when the written pair becomes the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_s);
    rd_ptr_d = rd_ptr_q + AW'(pop_s);
    level_d  = level_q + (AW+1)'(wr_s) - (AW+1)'(pop_s);
    valid_d  = (level_d != LVL_ZERO);
    head_d   = head_q;
    if (wr_s && (level_q == (AW+1)'(pop_s))) begin
      head_d = entry_s;
    end else if (level_d != LVL_ZERO) begin
      head_d = mem_q[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_RUN;
      ovf_q    <= 1'b0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign m_data   = head_q[2*WIDTH_PIX-1:0];
  assign m_eol    = head_q[EW-2];
  assign m_sof    = head_q[EW-1];
  assign m_valid  = valid_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pix_pair_stream_out.sv
// Scoreboard bench for pix_pair_stream_out with a small frame geometry.
module tb_pix_pair_stream_out;

  localparam int WP    = 8;
  localparam int BP    = 11;
  localparam int BL    = 10;
  localparam int AP    = 10;
  localparam int AL    = 4;
  localparam int DEPTH = 16;
  localparam int HTOT  = AP + 2;
  localparam int VTOT  = AL + 1;

  logic            clk_in = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic [BP-1:0]   pix = '0;
  logic [BL-1:0]   lines = '0;
  logic [2*WP-1:0] pair_in = '0;
  logic [2*WP-1:0] m_data;
  logic            m_sof;
  logic            m_eol;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [4:0]      level;
  logic            overflow;

  pix_pair_stream_out #(
    .WIDTH_PIX(WP), .BIT_DEPTH_PIX(BP), .BIT_DEPTH_LINES(BL),
    .ACTIVE_PIX(AP), .ACTIVE_LINES(AL), .DEPTH(DEPTH)
  ) dut (
    .clk_in(clk_in), .rst(rst), .enable(enable), .pix(pix), .lines(lines),
    .pair_in(pair_in), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
    .m_valid(m_valid), .m_ready(m_ready), .level(level), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  logic [2*WP+1:0] exp_q[$];
  int occ = 0;
  bit dropping = 1'b0;
  bit ovf_m = 1'b0;
  int px = 0;
  int ln = 0;
  int max_level = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pair_slot(input int x, input int y);
    return (x % 2 == 1) && (x < AP) && (y < AL);
  endfunction

  // One clock: reference model predicts the edge, then DUT state is compared.
  task automatic step();
    bit wr_req, sof, eol, pop, room, wr;
    pix     = BP'(px);
    lines   = BL'(ln);
    pair_in = (2*WP)'($urandom);
    wr_req  = enable && pair_slot(px, ln);
    sof     = (px == 1) && (ln == 0);
    eol     = (px == AP - 1);
    pop     = m_ready && (occ > 0);
    room    = (occ < DEPTH) || pop;
    wr      = 1'b0;
    if (wr_req) begin
      if (!dropping && room) wr = 1'b1;
      else if (!dropping) begin dropping = 1'b1; ovf_m = 1'b1; end
      else if (sof && room) begin wr = 1'b1; dropping = 1'b0; end
    end
    if (wr) exp_q.push_back({sof, eol, pair_in});
    occ = occ + int'(wr) - int'(pop);
    @(posedge clk_in);
    #1;
    check("level", int'(level), occ);
    check("m_valid", int'(m_valid), int'(occ > 0));
    check("overflow", int'(overflow), int'(ovf_m));
    if (enable) begin
      px++;
      if (px == HTOT) begin
        px = 0;
        ln = (ln + 1) % VTOT;
      end
    end
  endtask

  // Asynchronous reset pulse between two edges; model state is discarded with it.
  task automatic reset_pulse();
    #2;
    rst = 1'b0;
    exp_q.delete();
    occ = 0;
    dropping = 1'b0;
    ovf_m = 1'b0;
    #1;
    check("rst_level", int'(level), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    #3;
    rst = 1'b1;
  endtask

  // Monitor: any presented head must match the oldest expected pair.
  always @(negedge clk_in) begin
    if (rst && m_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL head: m_valid=1 with data %0h but nothing expected", m_data);
      end else begin
        check("m_data", int'(m_data), int'(exp_q[0][2*WP-1:0]));
        check("m_eol", int'(m_eol), int'(exp_q[0][2*WP]));
        check("m_sof", int'(m_sof), int'(exp_q[0][2*WP+1]));
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    rst = 1'b0;
    #10;
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_m_data", int'(m_data), 0);
    check("reset_m_sof", int'(m_sof), 0);
    check("reset_m_eol", int'(m_eol), 0);
    check("reset_level", int'(level), 0);
    check("reset_overflow", int'(overflow), 0);
    @(negedge clk_in);
    #1;
    rst = 1'b1;
    @(posedge clk_in);
    #1;

    // Streaming frame with a consumer that is always ready.
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (HTOT*VTOT) begin
      step();
      if (int'(level) > max_level) max_level = int'(level);
    end
    check("max_level_le1", max_level, 1);

    // Stalled consumer: 20 pairs offered, 16 kept, remainder of frame dropped.
    m_ready = 1'b0;
    repeat (HTOT*VTOT) step();
    check("stall_level_full", int'(level), 16);
    check("stall_overflow", int'(overflow), 1);
    m_ready = 1'b1;
    repeat (HTOT*VTOT) step();

    // Full FIFO with a simultaneous pop and write.
    reset_pulse();
    px = 0;
    ln = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 200 && occ < DEPTH; i++) step();
    check("fill_level", int'(level), 16);
    for (int i = 0; i < 20 && !pair_slot(px, ln); i++) step();
    m_ready = 1'b1;
    step();
    check("full_popwrite_level", int'(level), 16);
    check("full_popwrite_ovf", int'(overflow), 0);
    m_ready = 1'b0;
    enable = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 64 && occ > 0; i++) step();

    // Random enable and ready; a slow consumer forces frame drops.
    for (int i = 0; i < 500; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1) != 0;
      step();
    end
    for (int i = 0; i < 700; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 4) == 0);
      step();
    end

    // Mid-line reset with 9 pairs buffered; writing resumes without sof wait.
    reset_pulse();
    px = 0;
    ln = 0;
    enable = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 200 && occ < 9; i++) step();
    check("pre_reset_level", int'(level), 9);
    reset_pulse();
    for (int i = 0; i < 20 && !pair_slot(px, ln); i++) step();
    step();
    check("post_reset_m_valid", int'(m_valid), 1);
    check("post_reset_level", int'(level), 1);

    // No enable for a whole frame: nothing enters.
    reset_pulse();
    enable = 1'b0;
    repeat (HTOT*VTOT) begin
      m_ready = $urandom_range(0, 1) != 0;
      step();
    end
    check("noenable_level", int'(level), 0);
    check("noenable_m_valid", int'(m_valid), 0);

    m_ready = 1'b1;
    for (int i = 0; i < 64 && occ > 0; i++) step();
    @(negedge clk_in);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
